// File: rtl/yc_pkg.sv
// Shared types and constants for the Y/C encoder burst timing stage.
package yc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        BURST = 2'd2,
        HOLD  = 2'd3
    } yc_state_e;

    localparam int BURST_RANGE_W = 27;

    typedef struct packed {
        logic [6:0] start;
        logic [9:0] ntsc_end;
        logic [9:0] pal_end;
    } burst_range_t;

    localparam logic [7:0] DEF_NTSC_BURST_OFS  = 8'd128;
    localparam logic [7:0] DEF_PAL_BURST_OFS_A = 8'd96;
    localparam logic [7:0] DEF_PAL_BURST_OFS_B = 8'd160;
    localparam logic [9:0] CNT_MAX             = 10'd1023;

endpackage

// File: rtl/yc_burst_timing_phase_acc.sv
// Free-running subcarrier phase accumulator with a latched increment.
// phase is taken straight from the accumulator register's MSBs.
module yc_phase_acc #(
    parameter int ACC_W = 40,
    parameter int PH_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [ACC_W-1:0] inc,
    output logic [PH_W-1:0]  phase
);

    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] acc_q;

    // Increment latch and wrapping accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_q <= '0;
            acc_q <= '0;
        end else begin
            if (load) begin
                inc_q <= inc;
            end
            acc_q <= acc_q + inc_q;
        end
    end

    assign phase = acc_q[ACC_W-1 -: PH_W];

endmodule

// File: rtl/yc_burst_timing.sv
// Subcarrier phase, per-line colorburst gate and burst angle for the Y/C encoder.
// Line parameters are sampled on the hsync leading edge and held for the whole line.
module yc_burst_timing
    import yc_pkg::*;
#(
    parameter int              ACC_W           = 40,
    parameter int              PH_W            = 8,
    parameter logic [PH_W-1:0] NTSC_BURST_OFS  = PH_W'(DEF_NTSC_BURST_OFS),
    parameter logic [PH_W-1:0] PAL_BURST_OFS_A = PH_W'(DEF_PAL_BURST_OFS_A),
    parameter logic [PH_W-1:0] PAL_BURST_OFS_B = PH_W'(DEF_PAL_BURST_OFS_B)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ACC_W-1:0]         phase_inc,
    input  logic [BURST_RANGE_W-1:0] burst_range,
    input  logic                     pal,
    input  logic                     hsync,
    input  logic                     vsync,
    output logic [PH_W-1:0]          carrier_phase,
    output logic [PH_W-1:0]          burst_phase,
    output logic                     burst,
    output logic                     pal_line
);

    yc_state_e       state_q, state_d;
    logic [9:0]      cnt_q, cnt_d, cnt_inc_s;
    logic            hs_q, vs_q, first_q;
    logic            pal_l_q, pal_l_d;
    logic            pal_line_q, pal_line_d;
    burst_range_t    range_q, range_d;
    logic [PH_W-1:0] carrier_q, bphase_q, acc_phase_s, ofs_s;
    logic            lead_s, trail_s, vs_lead_s, degen_s;
    logic [9:0]      start_s, end_s;

    yc_phase_acc #(.ACC_W(ACC_W), .PH_W(PH_W)) u_phase_acc (
        .clk   (clk),
        .reset (reset),
        .load  (lead_s | first_q),
        .inc   (phase_inc),
        .phase (acc_phase_s)
    );

    assign lead_s    = hsync & ~hs_q;
    assign trail_s   = ~hsync & hs_q;
    assign vs_lead_s = vsync & ~vs_q;
    assign start_s   = {3'd0, range_q.start};
    assign end_s     = pal_l_q ? range_q.pal_end : range_q.ntsc_end;
    assign degen_s   = (end_s <= start_s);
    assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 10'd1;

    // Line FSM: wait for trailing edge, count to start, gate burst until end.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (trail_s) begin
                    cnt_d = 10'd0;
                    if (start_s == 10'd0) begin
                        state_d = degen_s ? HOLD : BURST;
                    end else begin
                        state_d = COUNT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            COUNT: begin
                cnt_d = cnt_inc_s;
                if (cnt_q == CNT_MAX) begin
                    state_d = HOLD;
                end else if (cnt_inc_s == start_s) begin
                    state_d = degen_s ? HOLD : BURST;
                end else begin
                    state_d = COUNT;
                end
            end
            BURST: begin
                cnt_d = cnt_inc_s;
                if ((cnt_q == CNT_MAX) || (cnt_inc_s == end_s)) begin
                    state_d = HOLD;
                end else begin
                    state_d = BURST;
                end
            end
            HOLD: begin
                state_d = HOLD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A new line always restarts the sequence, whatever the FSM was doing.
        if (lead_s) begin
            state_d = IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Line parameter latch and PAL V-switch next state.
    always_comb begin
        pal_l_d    = lead_s ? pal : pal_l_q;
        range_d    = lead_s ? burst_range_t'(burst_range) : range_q;
        if (vs_lead_s || !pal_l_q) begin
            pal_line_d = 1'b0;
        end else if (lead_s) begin
            pal_line_d = pal ? ~pal_line_q : 1'b0;
        end else begin
            pal_line_d = pal_line_q;
        end
        if (pal_l_q) begin
            ofs_s = pal_line_q ? PAL_BURST_OFS_B : PAL_BURST_OFS_A;
        end else begin
            ofs_s = NTSC_BURST_OFS;
        end
    end

    // State, edge-detect and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 10'd0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            first_q    <= 1'b1;
            pal_l_q    <= 1'b0;
            range_q    <= '0;
            pal_line_q <= 1'b0;
            carrier_q  <= '0;
            bphase_q   <= NTSC_BURST_OFS;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hs_q       <= hsync;
            vs_q       <= vsync;
            first_q    <= 1'b0;
            pal_l_q    <= pal_l_d;
            range_q    <= range_d;
            pal_line_q <= pal_line_d;
            carrier_q  <= acc_phase_s;
            bphase_q   <= acc_phase_s + ofs_s;
        end
    end

    assign carrier_phase = carrier_q;
    assign burst_phase   = bphase_q;
    assign burst         = (state_q == BURST) & ~vs_q;
    assign pal_line      = pal_line_q;

endmodule

// File: tb/tb_yc_burst_timing.sv
// Directed bench for yc_burst_timing: NTSC/PAL burst windows, V-switch, vsync blanking,
// mid-line input changes, degenerate range and mid-burst reset.
module tb_yc_burst_timing;
    import yc_pkg::*;

    localparam int HS_LEN = 100;
    localparam int TAIL   = 250;

    logic        clk = 1'b0;
    logic        reset;
    logic [39:0] phase_inc;
    logic [26:0] burst_range;
    logic        pal, hsync, vsync;
    logic [7:0]  carrier_phase, burst_phase;
    logic        burst, pal_line;

    int          n_checks = 0;
    int          n_errors = 0;
    int          ln_cnt, ln_first, vs_sum;
    logic [7:0]  ln_dcar, ln_ofs;
    logic        ln_pl;

    localparam logic [39:0] INC1 = 40'h0100000000;
    localparam logic [39:0] INC2 = 40'h0200000000;
    localparam logic [26:0] RNG_NORM  = {7'd49, 10'd169, 10'd157};
    localparam logic [26:0] RNG_DEGEN = {7'd80, 10'd60, 10'd60};

    yc_burst_timing dut (
        .clk           (clk),
        .reset         (reset),
        .phase_inc     (phase_inc),
        .burst_range   (burst_range),
        .pal           (pal),
        .hsync         (hsync),
        .vsync         (vsync),
        .carrier_phase (carrier_phase),
        .burst_phase   (burst_phase),
        .burst         (burst),
        .pal_line      (pal_line)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full line: hsync pulse, then measure the burst window and phase relationship.
    task automatic run_line(input logic nxt_pal, input logic [39:0] nxt_inc);
        logic [7:0] c20;
        c20      = 8'd0;
        ln_cnt   = 0;
        ln_first = 0;
        hsync    = 1'b1;
        repeat (HS_LEN) tick();
        hsync = 1'b0;
        for (int i = 1; i <= TAIL; i++) begin
            tick();
            if (i == 5) begin
                pal       = nxt_pal;
                phase_inc = nxt_inc;
            end
            if (burst === 1'b1) begin
                if (ln_cnt == 0) ln_first = i;
                ln_cnt++;
            end
            if (i == 20) c20 = carrier_phase;
            if (i == 21) begin
                ln_dcar = carrier_phase - c20;
                ln_ofs  = burst_phase - carrier_phase;
                ln_pl   = pal_line;
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        phase_inc   = INC1;
        burst_range = RNG_NORM;
        pal         = 1'b0;
        hsync       = 1'b0;
        vsync       = 1'b0;
        tick();
        tick();
        check("rst_carrier", 64'(carrier_phase), 64'd0);
        check("rst_bphase", 64'(burst_phase), 64'd128);
        check("rst_burst", 64'(burst), 64'd0);
        check("rst_pal_line", 64'(pal_line), 64'd0);
        reset = 1'b0;
        repeat (3) tick();

        // NTSC line
        run_line(1'b0, INC1);
        check("ntsc_len", 64'(ln_cnt), 64'd120);
        check("ntsc_first", 64'(ln_first), 64'd50);
        check("ntsc_dcar", 64'(ln_dcar), 64'd1);
        check("ntsc_ofs", 64'(ln_ofs), 64'd128);
        check("ntsc_pal_line", 64'(ln_pl), 64'd0);

        // PAL lines A, B, C
        pal = 1'b1;
        run_line(1'b1, INC1);
        check("palA_len", 64'(ln_cnt), 64'd108);
        check("palA_pl", 64'(ln_pl), 64'd0);
        check("palA_ofs", 64'(ln_ofs), 64'd96);
        run_line(1'b1, INC1);
        check("palB_len", 64'(ln_cnt), 64'd108);
        check("palB_pl", 64'(ln_pl), 64'd1);
        check("palB_ofs", 64'(ln_ofs), 64'd160);
        run_line(1'b1, INC1);
        check("palC_pl", 64'(ln_pl), 64'd0);
        check("palC_ofs", 64'(ln_ofs), 64'd96);
        run_line(1'b1, INC1);
        check("palD_pl", 64'(ln_pl), 64'd1);

        // vsync clears the V-switch and blanks burst
        check("pre_vs_pal_line", 64'(pal_line), 64'd1);
        vsync = 1'b1;
        tick();
        check("vs_clear_pal_line", 64'(pal_line), 64'd0);
        vs_sum = 0;
        for (int l = 0; l < 3; l++) begin
            run_line(1'b1, INC1);
            vs_sum += ln_cnt;
        end
        check("vs_burst_total", 64'(vs_sum), 64'd0);
        vsync = 1'b0;

        // Back to NTSC
        pal = 1'b0;
        run_line(1'b0, INC1);
        check("ntscH_len", 64'(ln_cnt), 64'd120);
        check("ntscH_pl", 64'(ln_pl), 64'd0);
        check("ntscH_ofs", 64'(ln_ofs), 64'd128);

        // Mid-line switch to PAL with doubled increment
        run_line(1'b1, INC2);
        check("mid_len", 64'(ln_cnt), 64'd120);
        check("mid_dcar", 64'(ln_dcar), 64'd1);
        check("mid_ofs", 64'(ln_ofs), 64'd128);
        run_line(1'b1, INC2);
        check("after_len", 64'(ln_cnt), 64'd108);
        check("after_dcar", 64'(ln_dcar), 64'd2);
        check("after_ofs", 64'(ln_ofs), 64'd96);
        check("after_pl", 64'(ln_pl), 64'd0);

        // Degenerate range: end below start
        burst_range = RNG_DEGEN;
        run_line(1'b1, INC2);
        check("degen_len", 64'(ln_cnt), 64'd0);
        check("degen_state", 64'(dut.state_q), 64'(HOLD));
        check("degen_cnt", 64'(dut.cnt_q), 64'd80);

        // Reset in the middle of a burst
        burst_range = RNG_NORM;
        pal         = 1'b0;
        phase_inc   = INC1;
        run_line(1'b0, INC1);
        check("pre_rst_len", 64'(ln_cnt), 64'd120);
        check("pre_rst_dcar", 64'(ln_dcar), 64'd1);
        hsync = 1'b1;
        repeat (HS_LEN) tick();
        hsync = 1'b0;
        repeat (70) tick();
        check("in_burst", 64'(burst), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_burst", 64'(burst), 64'd0);
        check("mid_rst_carrier", 64'(carrier_phase), 64'd0);
        check("mid_rst_bphase", 64'(burst_phase), 64'd128);
        tick();
        tick();
        reset  = 1'b0;
        vs_sum = 0;
        for (int i = 0; i < TAIL; i++) begin
            tick();
            if (burst === 1'b1) vs_sum++;
        end
        check("post_rst_no_burst", 64'(vs_sum), 64'd0);
        run_line(1'b0, INC1);
        check("post_rst_len", 64'(ln_cnt), 64'd120);
        check("post_rst_first", 64'(ln_first), 64'd50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
